// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII transmit framer (GMII_TX_PAD_EN adds the PAD state).
package gmii_tx_pkg;

`ifdef GMII_TX_PAD_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_IFG
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_FCS, ST_IFG
    } state_t;
`endif

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_d8.sv
// Reflected CRC-32 advanced by one byte, LSB first; purely combinational, no flow control.
module crc32_d8
    import gmii_tx_pkg::*;
(
    input  logic [31:0] i_crc_in,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc_out
);

    logic [31:0] w_c;

    always_comb begin
        w_c = i_crc_in ^ {24'h000000, i_data};
        for (int i = 0; i < 8; i++) begin
            w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
        end
        o_crc_out = w_c;
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII TX framer: preamble/SFD, payload, zero pad when GMII_TX_PAD_EN, CRC-32 FCS, inter-frame gap.
// All outputs registered; a byte accepted on one edge is on gmii_txd the next cycle; tx_ready only in SFD/DATA.
module gmii_tx_framer
    import gmii_tx_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 12,
    parameter int MIN_FRAME    = 60
) (
    input  logic       gmii_tx_clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_underrun
);

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN);
    localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_txd, w_txd_nxt;
    logic        r_en, w_en_nxt;
    logic        r_ready, w_ready_nxt;
    logic        r_busy;
    logic        r_done, w_done_nxt;
    logic        r_underrun, w_underrun_nxt;
    logic [31:0] r_crc, w_crc_nxt, w_crc_upd;
    logic [7:0]  r_sub, w_sub_nxt;
    logic [23:0] r_fcs, w_fcs_nxt;
    logic [7:0]  w_crc_byte;
    logic        w_start, w_fcs_go, w_pad_go;
    logic [31:0] w_fcs_word;

`ifdef GMII_TX_PAD_EN
    localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME);

    logic [10:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic        w_pad_more;

    assign w_cnt_inc  = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
    assign w_pad_more = (r_cnt < MIN_CNT);
    // Pad bytes are only ever generated once the payload has ended (tx_ready low).
    assign w_crc_byte = (r_state == ST_PAD || !r_ready) ? 8'h00 : tx_data;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^MIN_FRAME;
    assign w_crc_byte   = tx_data;
`endif

    crc32_d8 u_crc (
        .i_crc_in  (r_crc),
        .i_data    (w_crc_byte),
        .o_crc_out (w_crc_upd)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_txd_nxt      = 8'h00;
        w_en_nxt       = 1'b0;
        w_ready_nxt    = 1'b0;
        w_done_nxt     = 1'b0;
        w_underrun_nxt = 1'b0;
        w_crc_nxt      = r_crc;
        w_sub_nxt      = r_sub;
        w_fcs_nxt      = r_fcs;
        w_start        = 1'b0;
        w_fcs_go       = 1'b0;
        w_pad_go       = 1'b0;
        w_fcs_word     = ~r_crc;
`ifdef GMII_TX_PAD_EN
        w_cnt_nxt      = r_cnt;
`endif
        case (r_state)
            ST_IDLE: w_start = tx_valid;
            ST_PRE: begin
                w_en_nxt = 1'b1;
                if (r_sub == PRE_LAST) begin
                    w_state_nxt = ST_SFD;
                    w_txd_nxt   = SFD_BYTE;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_txd_nxt = PREAMBLE_BYTE;
                    w_sub_nxt = r_sub + 8'd1;
                end
            end
            ST_SFD, ST_DATA: begin
                if (r_ready && tx_valid) begin
                    w_state_nxt = ST_DATA;
                    w_txd_nxt   = tx_data;
                    w_en_nxt    = 1'b1;
                    w_ready_nxt = !tx_last;
                    w_crc_nxt   = w_crc_upd;
`ifdef GMII_TX_PAD_EN
                    w_cnt_nxt   = w_cnt_inc;
`endif
                end else if (r_ready) begin
                    // Sending the un-inverted register guarantees the receiver sees a bad FCS.
                    w_underrun_nxt = 1'b1;
                    w_fcs_word     = r_crc;
                    w_fcs_go       = 1'b1;
                end else begin
                    w_fcs_go = 1'b1;
`ifdef GMII_TX_PAD_EN
                    if (w_pad_more) begin
                        w_fcs_go = 1'b0;
                        w_pad_go = 1'b1;
                    end
`endif
                end
            end
`ifdef GMII_TX_PAD_EN
            ST_PAD: begin
                w_pad_go = w_pad_more;
                w_fcs_go = !w_pad_more;
            end
`endif
            ST_FCS: begin
                if (r_sub == 8'd4) begin
                    w_state_nxt = ST_IFG;
                    w_sub_nxt   = 8'd1;
                end else begin
                    w_txd_nxt  = r_fcs[7:0];
                    w_en_nxt   = 1'b1;
                    w_fcs_nxt  = {8'h00, r_fcs[23:8]};
                    w_sub_nxt  = r_sub + 8'd1;
                    w_done_nxt = (r_sub == 8'd3);
                end
            end
            ST_IFG: begin
                if (r_sub == IFG_LAST) begin
                    w_start = tx_valid;
                    if (!tx_valid) w_state_nxt = ST_IDLE;
                end else begin
                    w_sub_nxt = r_sub + 8'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_start) begin
            w_state_nxt = ST_PRE;
            w_txd_nxt   = PREAMBLE_BYTE;
            w_en_nxt    = 1'b1;
            w_sub_nxt   = 8'd1;
            w_crc_nxt   = CRC_INIT;
`ifdef GMII_TX_PAD_EN
            w_cnt_nxt   = 11'd0;
`endif
        end
`ifdef GMII_TX_PAD_EN
        if (w_pad_go) begin
            w_state_nxt = ST_PAD;
            w_txd_nxt   = 8'h00;
            w_en_nxt    = 1'b1;
            w_crc_nxt   = w_crc_upd;
            w_cnt_nxt   = w_cnt_inc;
        end
`endif
        if (w_fcs_go) begin
            w_state_nxt = ST_FCS;
            w_txd_nxt   = w_fcs_word[7:0];
            w_en_nxt    = 1'b1;
            w_fcs_nxt   = w_fcs_word[31:8];
            w_sub_nxt   = 8'd1;
        end
    end

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_txd      <= 8'h00;
            r_en       <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_crc      <= CRC_INIT;
            r_sub      <= 8'd0;
            r_fcs      <= 24'h000000;
`ifdef GMII_TX_PAD_EN
            r_cnt      <= 11'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_txd      <= w_txd_nxt;
            r_en       <= w_en_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
            r_underrun <= w_underrun_nxt;
            r_crc      <= w_crc_nxt;
            r_sub      <= w_sub_nxt;
            r_fcs      <= w_fcs_nxt;
`ifdef GMII_TX_PAD_EN
            r_cnt      <= w_cnt_nxt;
`endif
        end
    end

    assign tx_ready    = r_ready;
    assign gmii_txd    = r_txd;
    assign gmii_tx_en  = r_en;
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;
    assign tx_underrun = r_underrun;

endmodule
